pool_nl_accumulator: RTL and testbench

- Sits directly downstream of the pool_nl adder tree; consumes the tree's registered sum.
- Tracks which tree outputs are valid across the tree's enable-gated pipeline.
- Accumulates NUM_GROUPS partial sums per output pixel, then adds bias, applies optional ReLU, right-shifts, and saturates.
- Presents one result per pixel on a valid/ready interface to the output buffer.

---
 rtl/pool_nl_pkg.sv | 35 +++
 rtl/pool_nl_accumulator_if.sv | 19 +
 rtl/pool_nl_valid_track.sv | 35 +++
 rtl/pool_nl_accumulator.sv | 118 +++++++++++
 tb/tb_pool_nl_accumulator.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pool_nl_pkg.sv
// Shared types, widths and the output saturation helper for the pool_nl accumulator.
`ifndef WID_PE_BITS
`define WID_PE_BITS 16
`endif

package pool_nl_pkg;
    localparam int DATA_W  = `WID_PE_BITS;
    localparam int ACC_W   = 32;
    localparam int GRP_W   = 5;
    localparam int SHIFT_W = 5;

    localparam longint SAT_MAX_L = (64'sd1 <<< (DATA_W - 1)) - 64'sd1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(SAT_MAX_L);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-SAT_MAX_L - 64'sd1);

    typedef enum logic [1:0] {IDLE, ACCUM, FINAL} state_t;

    typedef struct packed {
        logic [GRP_W-1:0]   num_groups;
        logic [DATA_W-1:0]  bias;
        logic [SHIFT_W-1:0] shift;
        logic               relu_en;
    } cfg_t;

    function automatic logic signed [DATA_W-1:0] sat_shift(
        input logic signed [ACC_W-1:0] acc,
        input logic [SHIFT_W-1:0]      shift
    );
        logic signed [ACC_W-1:0] r;
        r = acc >>> shift;
        if (r > SAT_MAX) return SAT_MAX[DATA_W-1:0];
        if (r < SAT_MIN) return SAT_MIN[DATA_W-1:0];
        return r[DATA_W-1:0];
    endfunction
endpackage

// File: rtl/pool_nl_accumulator_if.sv
// Tree-side and output-side signals of the pool_nl accumulator.
interface pool_nl_accumulator_if;
    logic                                     adder_enable;
    logic                                     mac_valid;
    logic signed [pool_nl_pkg::DATA_W-1:0]    tree_sum;
    logic                                     acc_stall;
    logic signed [pool_nl_pkg::DATA_W-1:0]    out_data;
    logic                                     out_valid;
    logic                                     out_ready;

    modport master (
        output adder_enable, mac_valid, tree_sum, out_ready,
        input  acc_stall, out_data, out_valid
    );
    modport slave (
        input  adder_enable, mac_valid, tree_sum, out_ready,
        output acc_stall, out_data, out_valid
    );
endinterface

// File: rtl/pool_nl_valid_track.sv
// Follows mac_valid tags through the enable-gated adder tree and flags sums that would be overwritten.
module pool_nl_valid_track #(
    parameter int TREE_LAT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic adder_enable,
    input  logic mac_valid,
    input  logic clear,
    output logic fresh,
    output logic overrun_err
);
    // fresh is the top tag stage; unlike the lower stages it holds until consumed
    logic [TREE_LAT-2:0] tag_sr;
    logic                arrive;

    assign arrive = adder_enable && tag_sr[TREE_LAT-2];

    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_sr      <= '0;
            fresh       <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (adder_enable)
                tag_sr <= (tag_sr << 1) | (TREE_LAT-1)'(mac_valid);
            if (arrive)
                fresh <= 1'b1;
            else if (clear)
                fresh <= 1'b0;
            if (fresh && !clear && arrive)
                overrun_err <= 1'b1;
        end
    end
endmodule

// File: rtl/pool_nl_accumulator.sv
// Accumulates NUM_GROUPS tree sums per pixel, then bias, optional ReLU, shift and saturate.
module pool_nl_accumulator
    import pool_nl_pkg::*;
#(
    parameter int TREE_LAT = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    pool_nl_accumulator_if.slave       bus,
    input  logic                       start,
    input  logic [GRP_W-1:0]           cfg_num_groups,
    input  logic signed [DATA_W-1:0]   cfg_bias,
    input  logic [SHIFT_W-1:0]         cfg_shift,
    input  logic                       cfg_relu_en,
    output logic                       overrun_err
);
    state_t                  state;
    cfg_t                    cfg, pend_cfg, new_cfg, cur_cfg;
    logic                    pend;
    logic [GRP_W-1:0]        group_cnt;
    logic signed [ACC_W-1:0] acc, biased;
    logic                    fresh, clear, consume, relatch_now, fire;

    pool_nl_valid_track #(.TREE_LAT(TREE_LAT)) u_track (
        .clk          (clk),
        .rst          (rst),
        .adder_enable (bus.adder_enable),
        .mac_valid    (bus.mac_valid),
        .clear        (clear),
        .fresh        (fresh),
        .overrun_err  (overrun_err)
    );

    always_comb begin
        new_cfg            = '0;
        new_cfg.num_groups = (cfg_num_groups == '0) ? GRP_W'(1) : cfg_num_groups;
        new_cfg.bias       = cfg_bias;
        new_cfg.shift      = cfg_shift;
        new_cfg.relu_en    = cfg_relu_en;
    end

    // A start at a pixel boundary takes effect for the sum consumed in the same cycle
    assign relatch_now = start && (state == ACCUM) && (group_cnt == '0);
    assign cur_cfg     = relatch_now ? new_cfg : cfg;
    assign clear       = fresh && (state != FINAL);
    assign consume     = fresh && (state == ACCUM);
    assign fire        = (state == FINAL) && (!bus.out_valid || bus.out_ready);
    assign bus.acc_stall = (state == FINAL) &&
                           ((bus.out_valid && !bus.out_ready) || fresh);

    always_comb begin
        biased = acc + ACC_W'($signed(cfg.bias));
        if (cfg.relu_en && biased[ACC_W-1])
            biased = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            cfg           <= '0;
            pend_cfg      <= '0;
            pend          <= 1'b0;
            group_cnt     <= '0;
            acc           <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
        end else begin
            if (bus.out_valid && bus.out_ready)
                bus.out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cfg       <= new_cfg;
                        pend      <= 1'b0;
                        group_cnt <= '0;
                        state     <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (relatch_now) begin
                        cfg  <= new_cfg;
                        pend <= 1'b0;
                    end else if (start) begin
                        pend     <= 1'b1;
                        pend_cfg <= new_cfg;
                    end
                    if (consume) begin
                        acc <= (group_cnt == '0) ? ACC_W'(bus.tree_sum)
                                                 : acc + ACC_W'(bus.tree_sum);
                        if (group_cnt == cur_cfg.num_groups - GRP_W'(1)) begin
                            group_cnt <= '0;
                            state     <= FINAL;
                        end else begin
                            group_cnt <= group_cnt + GRP_W'(1);
                        end
                    end
                end
                FINAL: begin
                    if (start) begin
                        pend     <= 1'b1;
                        pend_cfg <= new_cfg;
                    end
                    if (fire) begin
                        bus.out_data  <= sat_shift(biased, cfg.shift);
                        bus.out_valid <= 1'b1;
                        state         <= ACCUM;
                        pend          <= 1'b0;
                        if (start)
                            cfg <= new_cfg;
                        else if (pend)
                            cfg <= pend_cfg;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pool_nl_accumulator.sv
// Randomized bench for pool_nl_accumulator: a behavioural tree feeds tagged sums, a pixel-level model predicts outputs.
module tb_pool_nl_accumulator;
    import pool_nl_pkg::*;

    localparam int TREE_LAT = 3;
    localparam int NONE = -999999;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [GRP_W-1:0] cfg_num_groups;
    logic signed [DATA_W-1:0] cfg_bias;
    logic [SHIFT_W-1:0] cfg_shift;
    logic cfg_relu_en;
    logic overrun_err;
    logic signed [DATA_W-1:0] tree_in;
    logic signed [DATA_W-1:0] stage [TREE_LAT];

    int checks = 0;
    int errors = 0;
    int got_q[$];
    int exp_q[$];

    always #5 clk = ~clk;

    pool_nl_accumulator_if bus();

    pool_nl_accumulator #(.TREE_LAT(TREE_LAT)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .start          (start),
        .cfg_num_groups (cfg_num_groups),
        .cfg_bias       (cfg_bias),
        .cfg_shift      (cfg_shift),
        .cfg_relu_en    (cfg_relu_en),
        .overrun_err    (overrun_err)
    );

    // upstream adder tree: a plain TREE_LAT-deep delay line advancing on enable
    always @(posedge clk) begin
        if (bus.adder_enable) begin
            stage[0] <= tree_in;
            for (int k = 1; k < TREE_LAT; k++) stage[k] <= stage[k-1];
        end
    end
    assign bus.tree_sum = stage[TREE_LAT-1];

    always @(negedge clk)
        if (rst && bus.out_valid && bus.out_ready) got_q.push_back(int'(bus.out_data));

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // pixel-level reference: sum groups, add bias, ReLU, floor shift, clamp
    function automatic void build_expected(input int vals[$], input int ng, input int bias,
                                           input int shift, input bit relu);
        int g;
        longint s, lim;
        exp_q.delete();
        g = (ng == 0) ? 1 : ng;
        lim = longint'(1) << (DATA_W - 1);
        for (int p = 0; p + g <= vals.size(); p += g) begin
            s = bias;
            for (int k = 0; k < g; k++) s += vals[p+k];
            if (relu && s < 0) s = 0;
            s = s >>> shift;
            if (s > lim - 1) s = lim - 1;
            if (s < -lim) s = -lim;
            exp_q.push_back(int'(s));
        end
    endfunction

    function automatic int got_at(input int k);
        return (k < got_q.size()) ? got_q[k] : NONE;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        bus.adder_enable = 1'b0; bus.mac_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        got_q.delete();
    endtask

    task automatic do_start(input int ng, input int bias, input int shift, input bit relu);
        @(posedge clk); #1;
        start = 1'b1;
        cfg_num_groups = GRP_W'(ng);
        cfg_bias = DATA_W'(bias);
        cfg_shift = SHIFT_W'(shift);
        cfg_relu_en = relu;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // controller: honours acc_stall, inserts random bubbles and random backpressure
    task automatic run_stream(input int vals[$], input int exp_n, input int en_pct,
                              input int rdy_pct, input int max_cyc);
        int idx = 0;
        int cyc = 0;
        while (cyc < max_cyc && (idx < vals.size() || got_q.size() < exp_n)) begin
            @(posedge clk); #1;
            bus.out_ready = ($urandom_range(99) < rdy_pct);
            #1;
            bus.adder_enable = 1'b0;
            bus.mac_valid = 1'b0;
            if (!bus.acc_stall && $urandom_range(99) < en_pct) begin
                bus.adder_enable = 1'b1;
                if (idx < vals.size() && $urandom_range(3) != 0) begin
                    bus.mac_valid = 1'b1;
                    tree_in = DATA_W'(vals[idx]);
                    idx++;
                end else begin
                    tree_in = DATA_W'($urandom);
                end
            end
            cyc++;
        end
    endtask

    task automatic flush(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.out_ready = 1'b1;
            #1;
            bus.adder_enable = !bus.acc_stall;
            bus.mac_valid = 1'b0;
        end
    endtask

    task automatic test_overrun();
        int s[4];
        do_reset();
        do_start(1, 0, 0, 0);
        for (int k = 0; k < 4; k++) s[k] = $urandom_range(0, 2000) - 1000;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            bus.adder_enable = 1'b1;
            bus.mac_valid = (k < 4);
            tree_in = DATA_W'((k < 4) ? s[k] : 0);
        end
        #2;
        checks++; if (overrun_err !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b want 1", overrun_err); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL overrun_hold_valid: got %b want 1", bus.out_valid); end
        checks++; if (int'(bus.out_data) !== s[0]) begin errors++; $display("FAIL overrun_hold_data: got %0d want %0d", bus.out_data, s[0]); end
        checks++; if (bus.acc_stall !== 1'b1) begin errors++; $display("FAIL overrun_stall: got %b want 1", bus.acc_stall); end
    endtask

    task automatic test_reset();
        int v[$];
        do_reset();
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %0d want 0", bus.out_data); end
        checks++; if (bus.acc_stall !== 1'b0) begin errors++; $display("FAIL reset_acc_stall: got %b want 0", bus.acc_stall); end
        checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun_err); end
        // no start after reset: sums must be dropped in IDLE
        v = '{321, -45};
        run_stream(v, 0, 100, 100, 50);
        flush(10);
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL reset_idle_drop: got %0d outputs want 0", got_q.size()); end
    endtask

    task automatic test_single_latency();
        do_reset();
        do_start(1, 0, 0, 0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1; bus.adder_enable = 1'b1; bus.mac_valid = 1'b1; tree_in = 100;
        @(posedge clk); #1;
        bus.mac_valid = 1'b0;
        repeat (TREE_LAT) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL latency_early: got %b want 0", bus.out_valid); end
        @(posedge clk); @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL latency_valid: got %b want 1", bus.out_valid); end
        checks++; if (int'(bus.out_data) !== 100) begin errors++; $display("FAIL latency_data: got %0d want 100", bus.out_data); end
        flush(6);
        checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL latency_count: got %0d want 1", got_q.size()); end
    endtask

    task automatic test_four_groups();
        int v[$];
        v = '{10, -3, 7, 1};
        do_reset();
        do_start(4, 5, 1, 0);
        run_stream(v, 1, 70, 100, 300);
        flush(8);
        build_expected(v, 4, 5, 1, 0);
        checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL four_count: got %0d want 1", got_q.size()); end
        checks++; if (got_at(0) !== exp_q[0]) begin errors++; $display("FAIL four_data: got %0d want %0d", got_at(0), exp_q[0]); end
    endtask

    task automatic test_relu_sat();
        int v[$];
        int ng, relu;
        for (int c = 0; c < 3; c++) begin
            case (c)
                0: begin v = '{-50}; ng = 1; relu = 1; end
                1: begin v = '{10000, 10000, 10000, 10000}; ng = 4; relu = 0; end
                default: begin v = '{-10000, -10000, -10000, -10000}; ng = 4; relu = 0; end
            endcase
            do_reset();
            do_start(ng, 0, 0, relu[0]);
            run_stream(v, 1, 80, 100, 300);
            flush(8);
            build_expected(v, ng, 0, 0, relu[0]);
            checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL relu_sat_count case %0d: got %0d want 1", c, got_q.size()); end
            checks++; if (got_at(0) !== exp_q[0]) begin errors++; $display("FAIL relu_sat_data case %0d: got %0d want %0d", c, got_at(0), exp_q[0]); end
        end
    endtask

    task automatic test_backpressure();
        int v[$];
        int none[$];
        v = '{$urandom_range(0, 3000) - 1500, $urandom_range(0, 3000) - 1500};
        do_reset();
        do_start(1, 0, 0, 0);
        run_stream(v, 99, 100, 0, 30);
        checks++; if (bus.acc_stall !== 1'b1) begin errors++; $display("FAIL bp_stall: got %b want 1", bus.acc_stall); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1", bus.out_valid); end
        checks++; if (int'(bus.out_data) !== v[0]) begin errors++; $display("FAIL bp_hold_data: got %0d want %0d", bus.out_data, v[0]); end
        checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL bp_overrun: got %b want 0", overrun_err); end
        run_stream(none, 2, 100, 100, 100);
        flush(6);
        checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL bp_count: got %0d want 2", got_q.size()); end
        checks++; if (got_at(0) !== v[0]) begin errors++; $display("FAIL bp_first: got %0d want %0d", got_at(0), v[0]); end
        checks++; if (got_at(1) !== v[1]) begin errors++; $display("FAIL bp_second: got %0d want %0d", got_at(1), v[1]); end
    endtask

    task automatic test_bubbles();
        int en_pat[6] = '{1, 0, 1, 1, 0, 1};
        int mv_pat[6] = '{1, 0, 0, 1, 0, 0};
        int a, b, step, cyc;
        a = $urandom_range(0, 4000) - 2000;
        b = $urandom_range(0, 4000) - 2000;
        do_reset();
        do_start(1, 0, 0, 0);
        step = 0; cyc = 0;
        while (step < 6 && cyc < 40) begin
            @(posedge clk); #1;
            bus.out_ready = 1'b1;
            #1;
            if (bus.acc_stall) begin
                bus.adder_enable = 1'b0; bus.mac_valid = 1'b0;
            end else begin
                bus.adder_enable = en_pat[step][0];
                bus.mac_valid = mv_pat[step][0];
                tree_in = (mv_pat[step] == 0) ? DATA_W'($urandom) : DATA_W'((step == 0) ? a : b);
                step++;
            end
            cyc++;
        end
        flush(10);
        checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL bubble_count: got %0d want 2", got_q.size()); end
        checks++; if (got_at(0) !== a) begin errors++; $display("FAIL bubble_first: got %0d want %0d", got_at(0), a); end
        checks++; if (got_at(1) !== b) begin errors++; $display("FAIL bubble_second: got %0d want %0d", got_at(1), b); end
    endtask

    task automatic test_reset_mid();
        int v[$];
        int w[$];
        v = '{5000, 6000};
        w = '{$urandom_range(0, 200), $urandom_range(0, 200), $urandom_range(0, 200), $urandom_range(0, 200)};
        do_reset();
        do_start(4, 0, 0, 0);
        run_stream(v, 0, 100, 100, 50);
        flush(6);
        @(posedge clk); #1;
        rst = 1'b0; bus.adder_enable = 1'b0; bus.mac_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.acc_stall !== 1'b0) begin errors++; $display("FAIL midrst_stall: got %b want 0", bus.acc_stall); end
        v = '{777};
        run_stream(v, 0, 100, 100, 50);
        flush(8);
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL midrst_idle_drop: got %0d outputs want 0", got_q.size()); end
        do_start(4, 0, 0, 0);
        run_stream(w, 1, 70, 100, 300);
        flush(8);
        build_expected(w, 4, 0, 0, 0);
        checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL midrst_count: got %0d want 1", got_q.size()); end
        checks++; if (got_at(0) !== exp_q[0]) begin errors++; $display("FAIL midrst_data: got %0d want %0d", got_at(0), exp_q[0]); end
    endtask

    task automatic test_random();
        int v[$];
        int ng, g, bias, shift, npix;
        bit relu;
        for (int t = 0; t < 8; t++) begin
            ng = $urandom_range(0, 5);
            g = (ng == 0) ? 1 : ng;
            bias = $urandom_range(0, 400) - 200;
            shift = $urandom_range(0, 4);
            relu = 1'($urandom_range(1));
            npix = $urandom_range(1, 4);
            v.delete();
            for (int k = 0; k < g * npix; k++) v.push_back($urandom_range(0, 40000) - 20000);
            do_reset();
            do_start(ng, bias, shift, relu);
            run_stream(v, npix, 60, 50, 3000);
            flush(8);
            build_expected(v, ng, bias, shift, relu);
            checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count trial %0d: got %0d want %0d", t, got_q.size(), exp_q.size()); end
            for (int k = 0; k < exp_q.size(); k++) begin
                checks++; if (got_at(k) !== exp_q[k]) begin errors++; $display("FAIL rand_data trial %0d pix %0d: got %0d want %0d", t, k, got_at(k), exp_q[k]); end
            end
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0;
        cfg_num_groups = '0; cfg_bias = '0; cfg_shift = '0; cfg_relu_en = 1'b0;
        bus.adder_enable = 1'b0; bus.mac_valid = 1'b0; bus.out_ready = 1'b1;
        tree_in = '0;
        test_overrun();
        test_reset();
        test_single_latency();
        test_four_groups();
        test_relu_sat();
        test_backpressure();
        test_bubbles();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
